top_module_fsm: RTL and testbench
=================================

// Module: top_module_fsm
// PURPOSE
//   Next-state logic for a 6-state one-hot FSM with states A..F on y[1]..y[6] and input w.
//   Y2 is the next-state bit for state B; Y4 is the next-state bit for state D.
//   Both are purely combinational and use no decoding beyond the literal equations.
//   The block also registers the full 6-bit next-state vector for downstream state-register reuse.
//   Transitions:
//     A: w=1->A, w=0->B    B: w=1->D, w=0->C    C: w=1->D, w=0->E
//     D: w=1->A, w=0->F    E: w=1->D, w=0->E    F: w=1->D, w=0->C
// PARAMETERS
//   none
// PORTS
//   clk      in   1  clock; only next_q uses it, rising edge
//   reset    in   1  synchronous, active-high reset; affects next_q only
//   y        in   6  [6:1] current state, one-hot: y[1]=A ... y[6]=F
//   w        in   1  FSM input
//   Y2       out  1  combinational next-state bit for B
//   Y4       out  1  combinational next-state bit for D
//   next_q   out  6  [6:1] registered next-state vector
// BEHAVIOUR
//   - Y2 = y[1] & ~w.
//   - Y4 = (y[2] | y[3] | y[5] | y[6]) & w.
//   - Y2 and Y4 have zero latency and settle within the same timestep as a y/w change.
//   - Y2 and Y4 are independent of clk and reset; reset asserted does not force them.
//   - No one-hot check is made: any y pattern, including 0 or multi-hot, is evaluated bitwise by the equations.
//   - Y4 must be exactly the OR-form above. The form ~y[1]&~y[4]&w is not acceptable, because it differs on y=0.
//   - Full next-state equations (N[6:1]):
//       N1 = (y[1] | y[4]) & w
//       N2 = Y2
//       N3 = (y[2] | y[6]) & ~w
//       N4 = Y4
//       N5 = (y[3] | y[5]) & ~w
//       N6 = y[4] & ~w
//   - next_q <= N on each rising clk edge.
//   - If reset is high at a rising edge, next_q <= 6'b000001 (state A); reset has priority over N.
//   - next_q is undefined before the first reset edge.
//   - Reset asserted mid-operation takes effect at the next edge only. Y2 and Y4 keep tracking their inputs throughout.
//   - Outputs carry no X when y and w are known.
// TESTING
//   - Exhaustive: all 64 y values x both w values -> Y2 and Y4 match the equations bit-exactly.
//   - One-hot sweep, 200 random vectors:
//       y=6'b000001, w=0 -> Y2=1, Y4=0
//       y=6'b000001, w=1 -> Y2=0, Y4=0
//       y=6'b000100, w=1 -> Y4=1
//       y=6'b001000, w=1 -> Y4=0
//   - Non-one-hot: y=6'b000000, w=1 -> Y4=0; y=6'b100010, w=1 -> Y4=1, Y2=0.
//   - Outputs change on both clk edges: drive new y/w at posedge and at negedge, and check immediately, with no clocked delay.
//   - Reset: reset=1 at a rising edge with y=6'b001000, w=0 -> next_q=6'b000001.
//     Then reset=0 with y=6'b001000, w=0 -> next_q=6'b100000 after one edge.
//   - Reset independence: hold reset=1, y=6'b000001, w=0 -> Y2=1 throughout.

Source files
------------

// File: rtl/top_module_fsm_if.sv
// Bundles the one-hot state inputs, FSM input and next-state outputs
// shared between the next-state block and whoever drives it.
interface top_module_fsm_if;
  logic [6:1] y;
  logic       w;
  logic       Y2;
  logic       Y4;
  logic [6:1] next_q;

  modport master (output y, output w, input Y2, input Y4, input next_q);
  modport slave  (input y, input w, output Y2, output Y4, output next_q);
endinterface

// File: rtl/top_module_fsm.sv
// Next-state logic for a six-state one-hot FSM (A..F on y[1]..y[6]), with
// combinational B/D next-state bits and a registered copy of the full vector.
module top_module_fsm (
  input logic             clk,
  input logic             reset,
  top_module_fsm_if.slave bus
);

  logic [6:1] next_d;
  logic [6:1] next_q;

  // Literal bitwise equations: no one-hot check, so zero or multi-hot
  // patterns simply OR together the contributions of every set bit.
  always_comb begin
    next_d    = '0;
    next_d[1] = (bus.y[1] | bus.y[4]) & bus.w;
    next_d[2] = bus.y[1] & ~bus.w;
    next_d[3] = (bus.y[2] | bus.y[6]) & ~bus.w;
    next_d[4] = (bus.y[2] | bus.y[3] | bus.y[5] | bus.y[6]) & bus.w;
    next_d[5] = (bus.y[3] | bus.y[5]) & ~bus.w;
    next_d[6] = bus.y[4] & ~bus.w;
  end

  always_ff @(posedge clk) begin
    if (reset) next_q <= 6'b000001;
    else       next_q <= next_d;
  end

  // Y2/Y4 bypass the register and ignore reset entirely.
  assign bus.Y2     = next_d[2];
  assign bus.Y4     = next_d[4];
  assign bus.next_q = next_q;

endmodule

// File: tb/tb_top_module_fsm.sv
// Scoreboard bench for top_module_fsm: expectations come from the FSM
// transition table and are queued at drive time, then popped at each check.
module tb_top_module_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  top_module_fsm_if bus();

  top_module_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // successor state index for each state under w=1 / w=0
  int succ_w1 [1:6] = '{1, 4, 4, 1, 4, 4};
  int succ_w0 [1:6] = '{2, 3, 5, 6, 5, 3};

  logic [1:0] exp_comb_q [$];
  logic [6:1] exp_next_q [$];

  function automatic logic [6:1] model_next(input logic [6:1] y, input logic w);
    logic [6:1] n;
    n = '0;
    for (int i = 1; i <= 6; i++)
      if (y[i]) n[w ? succ_w1[i] : succ_w0[i]] = 1'b1;
    return n;
  endfunction

  // drives y/w and queues the expected {Y2,Y4}; returns the full next vector
  task automatic drive(input logic [6:1] y, input logic w, output logic [6:1] n);
    bus.y = y;
    bus.w = w;
    n = model_next(y, w);
    exp_comb_q.push_back({n[2], n[4]});
  endtask

  task automatic test_reset();
    logic [6:1] n;
    logic [1:0] e;
    logic [6:1] en;
    reset = 1'b1;
    @(negedge clk);
    drive(6'b001000, 1'b0, n);
    exp_next_q.push_back(6'b000001);
    @(posedge clk); #1;
    en = exp_next_q.pop_front();
    n_checks++;
    if (bus.next_q !== en) begin
      n_fail++;
      $display("FAIL reset_next_q: got %b expected %b", bus.next_q, en);
    end
    e = exp_comb_q.pop_front();
    n_checks++;
    if ({bus.Y2, bus.Y4} !== e) begin
      n_fail++;
      $display("FAIL reset_comb: Y2Y4=%b expected %b", {bus.Y2, bus.Y4}, e);
    end
    reset = 1'b0;
    drive(6'b001000, 1'b0, n);
    exp_next_q.push_back(6'b100000);
    @(posedge clk); #1;
    en = exp_next_q.pop_front();
    n_checks++;
    if (bus.next_q !== en) begin
      n_fail++;
      $display("FAIL after_reset_next_q: got %b expected %b", bus.next_q, en);
    end
    e = exp_comb_q.pop_front();
    n_checks++;
    if ({bus.Y2, bus.Y4} !== e) begin
      n_fail++;
      $display("FAIL after_reset_comb: Y2Y4=%b expected %b", {bus.Y2, bus.Y4}, e);
    end
  endtask

  task automatic test_exhaustive();
    logic [6:1] n;
    logic [1:0] e;
    for (int v = 0; v < 128; v++) begin
      drive(v[5:0], v[6], n);
      #1;
      e = exp_comb_q.pop_front();
      n_checks++;
      if ({bus.Y2, bus.Y4} !== e) begin
        n_fail++;
        $display("FAIL exhaustive y=%b w=%b: Y2Y4=%b expected %b",
                 bus.y, bus.w, {bus.Y2, bus.Y4}, e);
      end
      #2;
    end
  endtask

  task automatic test_onehot_random();
    logic [6:1] n;
    logic [6:1] y;
    logic       w;
    logic [1:0] e;
    logic [6:1] en;
    for (int k = 0; k < 204; k++) begin
      case (k)
        0: begin y = 6'b000001; w = 1'b0; end
        1: begin y = 6'b000001; w = 1'b1; end
        2: begin y = 6'b000100; w = 1'b1; end
        3: begin y = 6'b001000; w = 1'b1; end
        default: begin
          y = 6'b000001 << $urandom_range(5, 0);
          w = 1'($urandom_range(1, 0));
        end
      endcase
      @(negedge clk);
      drive(y, w, n);
      exp_next_q.push_back(n);
      #1;
      e = exp_comb_q.pop_front();
      n_checks++;
      if ({bus.Y2, bus.Y4} !== e) begin
        n_fail++;
        $display("FAIL onehot y=%b w=%b: Y2Y4=%b expected %b", y, w, {bus.Y2, bus.Y4}, e);
      end
      @(posedge clk); #1;
      en = exp_next_q.pop_front();
      n_checks++;
      if (bus.next_q !== en) begin
        n_fail++;
        $display("FAIL onehot_next_q y=%b w=%b: got %b expected %b", y, w, bus.next_q, en);
      end
    end
  endtask

  task automatic test_non_onehot();
    logic [6:1] n;
    logic [1:0] e;
    logic [6:1] pats [4] = '{6'b000000, 6'b100010, 6'b111111, 6'b001001};
    for (int p = 0; p < 4; p++) begin
      for (int wv = 0; wv < 2; wv++) begin
        @(negedge clk);
        drive(pats[p], wv[0], n);
        exp_next_q.push_back(n);
        #1;
        e = exp_comb_q.pop_front();
        n_checks++;
        if ({bus.Y2, bus.Y4} !== e) begin
          n_fail++;
          $display("FAIL non_onehot y=%b w=%0d: Y2Y4=%b expected %b",
                   pats[p], wv, {bus.Y2, bus.Y4}, e);
        end
        @(posedge clk); #1;
        n = exp_next_q.pop_front();
        n_checks++;
        if (bus.next_q !== n) begin
          n_fail++;
          $display("FAIL non_onehot_next_q y=%b w=%0d: got %b expected %b",
                   pats[p], wv, bus.next_q, n);
        end
      end
    end
  endtask

  task automatic test_both_edges();
    logic [6:1] n;
    logic [1:0] e;
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) @(posedge clk);
      else            @(negedge clk);
      drive(6'($urandom_range(63, 0)), 1'($urandom_range(1, 0)), n);
      #1;
      e = exp_comb_q.pop_front();
      n_checks++;
      if ({bus.Y2, bus.Y4} !== e) begin
        n_fail++;
        $display("FAIL both_edges k=%0d y=%b w=%b: Y2Y4=%b expected %b",
                 k, bus.y, bus.w, {bus.Y2, bus.Y4}, e);
      end
    end
  endtask

  task automatic test_reset_independence();
    logic [6:1] n;
    logic [1:0] e;
    logic [6:1] en;
    // mid-operation reset: raised after a negedge, lands at the next posedge only
    @(negedge clk);
    drive(6'b000010, 1'b1, n);
    reset = 1'b1;
    #1;
    e = exp_comb_q.pop_front();
    n_checks++;
    if ({bus.Y2, bus.Y4} !== e) begin
      n_fail++;
      $display("FAIL midreset_comb: Y2Y4=%b expected %b", {bus.Y2, bus.Y4}, e);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(6'b000001, 1'b0, n);
      exp_next_q.push_back(6'b000001);
      #1;
      e = exp_comb_q.pop_front();
      n_checks++;
      if ({bus.Y2, bus.Y4} !== e || bus.Y2 !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold_comb k=%0d: Y2Y4=%b expected %b", k, {bus.Y2, bus.Y4}, e);
      end
      @(posedge clk); #1;
      en = exp_next_q.pop_front();
      n_checks++;
      if (bus.next_q !== en || bus.Y2 !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold_next_q k=%0d: next_q=%b Y2=%b expected %b Y2=1",
                 k, bus.next_q, bus.Y2, en);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.y = '0;
    bus.w = 1'b0;
    test_reset();
    test_exhaustive();
    test_onehot_random();
    test_non_onehot();
    test_both_edges();
    test_reset_independence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
